// File: rtl/tlc5615_pkg.sv
// Shared constants, state encoding and frame formatting for the TLC5615 DAC driver.
package tlc5615_pkg;

  localparam int DATA_W  = 10;
  localparam int FRAME_W = 16;
  localparam int PAD_HI  = 4;
  localparam int PAD_LO  = 2;
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  // Four leading zeros, the code, then two don't-care LSBs the DAC ignores.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] code);
    return {{PAD_HI{1'b0}}, code, {PAD_LO{1'b0}}};
  endfunction

endpackage

// File: rtl/dac_half_tick.sv
// Prescaler for serial peripheral clocks: one-cycle tick every DIV enabled cycles.
module dac_half_tick #(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/tlc5615_driver.sv
// TLC5615 serial DAC transmitter: 16-bit frame, MSB first, on a registered CS_N/SCLK/DIN link.
module tlc5615_driver
  import tlc5615_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int GAP_HALVES = 1
) (
  input  logic              CLOCK_50,
  input  logic              RST_N,
  input  logic              dac_req,
  input  logic [DATA_W-1:0] dac_data,
  output logic              dac_busy,
  output logic              dac_done,
  output logic              DAC_CS_N,
  output logic              DAC_SCLK,
  output logic              DAC_DIN
);

  localparam int GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_HALVES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               din_q, din_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [FRAME_W-1:0] frame_in;
  logic               tick;

  assign frame_in = build_frame(dac_data);

  dac_half_tick #(
    .DIV (CLK_DIV)
  ) u_half_tick (
    .clk   (CLOCK_50),
    .rst_n (RST_N),
    .en    (state_q != IDLE),
    .tick  (tick)
  );

  // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    din_d     = din_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dac_req) begin
          state_d   = SHIFT;
          shreg_d   = frame_in;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          din_d     = frame_in[FRAME_W-1];
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // DIN moves only together with the falling SCLK edge.
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = HOLD;
              din_d   = 1'b0;
            end else begin
              shreg_d   = shreg_q << 1;
              din_d     = shreg_q[FRAME_W-2];
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the shift register is reset too, so an aborted frame never leaks stale bits.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dac_busy = busy_q;
  assign dac_done = done_q;
  assign DAC_CS_N = cs_n_q;
  assign DAC_SCLK = sclk_q;
  assign DAC_DIN  = din_q;

endmodule
